// File: rtl/lfsr_sched_pkg.sv
// Shared types and constants for the LED LFSR sequencer.

package lfsr_sched_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StIdle,
        StRun,
        StStep
    } state_e;

    localparam logic [4:0] DefaultSeed = 5'b00001;

endpackage

// File: rtl/lfsr_sched_edge.sv
// Rising-edge detector on a conditioned button level.
// The previous-level register resets high so a button held through reset gives no edge.

module lfsr_sched_edge (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic edge_o
);

    logic prev_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= btn_i;
        end
    end

    assign edge_o = btn_i & ~prev_q;

endmodule

// File: rtl/lfsr_sched.sv
// LFSR sequencer: run/pause, single-step and reseed control with a RUN-mode prescaler.
// Define LFSR_SCHED_LOCKUP_DETECT_EN to reload the seed when the LFSR is seen all-zero.

module lfsr_sched
    import lfsr_sched_pkg::*;
#(
    parameter int unsigned      PRESCALE_W = 22,
    parameter int unsigned      WIDTH      = 5,
    parameter logic [WIDTH-1:0] SEED       = WIDTH'(DefaultSeed),
    parameter int unsigned      STEPS_W    = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               run_btn_i,
    input  logic               step_btn_i,
    input  logic               seed_btn_i,
    input  logic [WIDTH-1:0]   lfsr_data_i,
    output logic               lfsr_en_o,
    output logic               lfsr_load_o,
    output logic [WIDTH-1:0]   lfsr_seed_o,
    output logic               running_o,
    output logic [STEPS_W-1:0] steps_o,
    output logic               lockup_o
);

    logic run_edge, step_edge, seed_edge;

    lfsr_sched_edge u_run_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn_i   (run_btn_i),
        .edge_o  (run_edge)
    );

    lfsr_sched_edge u_step_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn_i   (step_btn_i),
        .edge_o  (step_edge)
    );

    lfsr_sched_edge u_seed_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn_i   (seed_btn_i),
        .edge_o  (seed_edge)
    );

    state_e                state_q, state_d;
    logic                  resume_q, resume_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  tick_q, tick_d;
    logic [STEPS_W-1:0]    steps_q, steps_d;
    logic                  lockup_q, lockup_d;
    logic                  lock_hit;
    logic                  en;

`ifdef LFSR_SCHED_LOCKUP_DETECT_EN
    assign lock_hit = (state_q != StLoad) && (lfsr_data_i == '0);
`else
    logic unused_data;
    assign lock_hit    = 1'b0;
    assign unused_data = ^lfsr_data_i;
`endif

    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        presc_d  = presc_q;
        tick_d   = 1'b0;

        unique case (state_q)
            StLoad: state_d = resume_q ? StRun : StIdle;
            StIdle: begin
                if (seed_edge) begin
                    state_d  = StLoad;
                    resume_d = 1'b0;
                end else if (run_edge) begin
                    state_d = StRun;
                end else if (step_edge) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (seed_edge) begin
                    state_d  = StLoad;
                    resume_d = 1'b1;
                end else if (run_edge) begin
                    state_d = StIdle;
                end
            end
            StStep:  state_d = StIdle;
            default: state_d = StLoad;
        endcase

        if (lock_hit) begin
            state_d  = StLoad;
            resume_d = (state_q == StRun);
        end

        // Prescaler only moves on RUN cycles that stay in RUN, so a pause keeps its phase
        // and an exit edge suppresses the wrap strobe.
        if (state_q == StLoad) begin
            presc_d = '0;
        end else if (state_q == StRun && state_d == StRun) begin
            presc_d = presc_q + 1'b1;
            tick_d  = &presc_q;
        end
    end

    assign en = tick_q | (state_q == StStep);

    always_comb begin
        steps_d  = steps_q;
        lockup_d = lockup_q | lock_hit;
        if (state_q == StLoad) begin
            steps_d = '0;
        end else if (en) begin
            steps_d = steps_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StLoad;
            resume_q <= 1'b0;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            steps_q  <= '0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            steps_q  <= steps_d;
            lockup_q <= lockup_d;
        end
    end

    assign lfsr_en_o   = en;
    assign lfsr_load_o = (state_q == StLoad);
    assign lfsr_seed_o = SEED;
    assign running_o   = (state_q == StRun);
    assign steps_o     = steps_q;
    assign lockup_o    = lockup_q;

endmodule

// File: tb/tb_lfsr_sched.sv
// Self-checking bench for lfsr_sched: directed vector table, corner sequences and random
// stimulus against a cycle-level behavioural model.

module tb_lfsr_sched;

    localparam int PW   = 3;
    localparam int W    = 5;
    localparam int SW   = 8;
    localparam int PMAX = (1 << PW) - 1;
    localparam int SMOD = 1 << SW;

`ifdef LFSR_SCHED_LOCKUP_DETECT_EN
    localparam bit LockDet = 1'b1;
`else
    localparam bit LockDet = 1'b0;
`endif

    localparam int M_LOAD = 0;
    localparam int M_IDLE = 1;
    localparam int M_RUN  = 2;
    localparam int M_STEP = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run_btn = 1'b0, step_btn = 1'b0, seed_btn = 1'b0;
    logic [W-1:0]  data = 5'd1;
    logic          en, load, running, lockup;
    logic [W-1:0]  seed;
    logic [SW-1:0] steps;

    int checks = 0;
    int failures = 0;

    lfsr_sched #(
        .PRESCALE_W (PW),
        .WIDTH      (W),
        .SEED       (5'b00001),
        .STEPS_W    (SW)
    ) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .run_btn_i   (run_btn),
        .step_btn_i  (step_btn),
        .seed_btn_i  (seed_btn),
        .lfsr_data_i (data),
        .lfsr_en_o   (en),
        .lfsr_load_o (load),
        .lfsr_seed_o (seed),
        .running_o   (running),
        .steps_o     (steps),
        .lockup_o    (lockup)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int m_mode, m_phase, m_steps;
    bit m_tick, m_resume, m_lock;
    bit m_prev_run, m_prev_step, m_prev_seed;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_LOAD; m_phase = 0; m_steps = 0;
        m_tick = 0; m_resume = 0; m_lock = 0;
        m_prev_run = 1; m_prev_step = 1; m_prev_seed = 1;
    endtask

    task automatic model_clock(input bit r, input bit st, input bit sd, input int d);
        bit er, est, es, en_now, hit;
        int nxt;
        er     = r && !m_prev_run;
        est    = st && !m_prev_step;
        es     = sd && !m_prev_seed;
        en_now = m_tick || (m_mode == M_STEP);
        hit    = LockDet && (m_mode != M_LOAD) && (d == 0);
        nxt    = m_mode;
        if (m_mode == M_LOAD) nxt = m_resume ? M_RUN : M_IDLE;
        else if (hit) begin
            nxt = M_LOAD; m_resume = (m_mode == M_RUN); m_lock = 1;
        end else if (m_mode == M_IDLE) begin
            if (es) begin nxt = M_LOAD; m_resume = 0; end
            else if (er) nxt = M_RUN;
            else if (est) nxt = M_STEP;
        end else if (m_mode == M_RUN) begin
            if (es) begin nxt = M_LOAD; m_resume = 1; end
            else if (er) nxt = M_IDLE;
        end else nxt = M_IDLE;

        m_tick = 0;
        if (m_mode == M_LOAD) begin
            m_phase = 0; m_steps = 0;
        end else begin
            if (en_now) m_steps = (m_steps + 1) % SMOD;
            if (m_mode == M_RUN && nxt == M_RUN) begin
                m_tick  = (m_phase == PMAX);
                m_phase = (m_phase + 1) % (PMAX + 1);
            end
        end
        m_mode = nxt;
        m_prev_run = r; m_prev_step = st; m_prev_seed = sd;
    endtask

    task automatic compare_model();
        check("m_en",      int'(en),      int'(m_tick || m_mode == M_STEP));
        check("m_load",    int'(load),    int'(m_mode == M_LOAD));
        check("m_running", int'(running), int'(m_mode == M_RUN));
        check("m_steps",   int'(steps),   m_steps);
        check("m_lockup",  int'(lockup),  int'(m_lock));
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic cycle(input bit r, input bit st, input bit sd, input int d);
        run_btn = r; step_btn = st; seed_btn = sd; data = W'(d);
        @(posedge clk);
        model_clock(r, st, sd, d);
        #1;
        compare_model();
    endtask

    task automatic do_reset(input bit hold_step);
        run_btn = 0; step_btn = hold_step; seed_btn = 0; data = 5'd1;
        rst = 1;
        #2;
        check("rst_load",   int'(load),    1);
        check("rst_en",     int'(en),      0);
        check("rst_steps",  int'(steps),   0);
        check("rst_lockup", int'(lockup),  0);
        check("rst_run",    int'(running), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    typedef struct {
        bit run, step, seed;
        bit exp_load, exp_en, exp_running;
        int exp_steps;
    } vec_t;

    vec_t tbl[18];
    int   cnt, lat;
    bit   lr, ls, ld;

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 1, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 0, 0, 1};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 1};
        tbl[4]  = '{1, 0, 0, 0, 0, 1, 1};
        tbl[5]  = '{1, 0, 0, 0, 0, 1, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 1};
        tbl[7]  = '{0, 0, 0, 0, 0, 1, 1};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 1, 1};
        tbl[10] = '{0, 0, 0, 0, 0, 1, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 1};
        tbl[12] = '{0, 0, 0, 0, 1, 1, 1};
        tbl[13] = '{0, 0, 0, 0, 0, 1, 2};
        tbl[14] = '{1, 0, 1, 1, 0, 0, 2};
        tbl[15] = '{0, 0, 0, 0, 0, 1, 0};
        tbl[16] = '{0, 1, 0, 0, 0, 1, 0};
        tbl[17] = '{1, 0, 0, 0, 0, 0, 0};

        #1;
        // Reset release: single load cycle, then quiet IDLE
        do_reset(0);
        check("t1_load_c1", int'(load), 1);
        check("t1_seed", int'(seed), 1);
        cycle(0, 0, 0, 1);
        check("t1_load_c2", int'(load), 0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            cycle(0, 0, 0, 1);
            if (en) cnt++;
        end
        check("t1_no_en", cnt, 0);
        check("t1_steps", int'(steps), 0);

        // Directed vector table
        do_reset(0);
        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].run, tbl[i].step, tbl[i].seed, 1);
            check($sformatf("tbl%0d_load", i), int'(load), int'(tbl[i].exp_load));
            check($sformatf("tbl%0d_en", i), int'(en), int'(tbl[i].exp_en));
            check($sformatf("tbl%0d_run", i), int'(running), int'(tbl[i].exp_running));
            check($sformatf("tbl%0d_steps", i), int'(steps), tbl[i].exp_steps);
        end

        // Button held through reset gives no edge
        do_reset(1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 1);
            if (en) cnt++;
        end
        check("held_no_step", cnt, 0);

        // Step held 10 cycles -> exactly one pulse
        do_reset(0);
        cycle(0, 0, 0, 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 0, 1);
            if (en) cnt++;
        end
        cycle(0, 0, 0, 1);
        check("t2_pulses", cnt, 1);
        check("t2_steps", int'(steps), 1);

        // RUN cadence, pause keeps phase, resume
        do_reset(0);
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 1);
        check("t3_running", int'(running), 1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, 0, 1);
            if (en) cnt++;
        end
        check("t3_pulses40", cnt, 5);
        cycle(0, 0, 0, 1);
        check("t3_steps5", int'(steps), 5);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 1);
        check("t3_paused", int'(running), 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 1);
            if (en) cnt++;
        end
        check("t3_pause_quiet", cnt, 0);
        cycle(1, 0, 0, 1);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, 1);
            lat++;
            if (en) break;
        end
        check("t3_resume_lat", lat, 5);

        // Simultaneous run+seed in IDLE -> LOAD wins
        do_reset(0);
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("t4_pre_steps", int'(steps), 1);
        cycle(1, 0, 1, 1);
        check("t4_load", int'(load), 1);
        check("t4_not_run", int'(running), 0);
        cycle(0, 0, 0, 1);
        check("t4_idle", int'(running), 0);
        check("t4_steps0", int'(steps), 0);

        // Seed during RUN -> reload and return to RUN with cleared prescaler
        do_reset(0);
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        check("t5_load", int'(load), 1);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, 1);
            lat++;
            if (lat == 1) check("t5_back_run", int'(running), 1);
            if (en) break;
        end
        check("t5_first_en", lat, 9);

        // All-zero LFSR state in RUN
        do_reset(0);
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
`ifdef LFSR_SCHED_LOCKUP_DETECT_EN
        check("t6_load", int'(load), 1);
        check("t6_lockup", int'(lockup), 1);
        cycle(0, 0, 0, 1);
        check("t6_rerun", int'(running), 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
        check("t6_sticky", int'(lockup), 1);
`else
        check("t6_no_load", int'(load), 0);
        check("t6_no_lockup", int'(lockup), 0);
        check("t6_still_run", int'(running), 1);
`endif

        // Random levels, occasional zero data and mid-run async reset
        do_reset(0);
        lr = 0; ls = 0; ld = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(0);
                lr = 0; ls = 0; ld = 0;
            end
            if ($urandom_range(0, 5) == 0) lr = ~lr;
            if ($urandom_range(0, 5) == 0) ls = ~ls;
            if ($urandom_range(0, 11) == 0) ld = ~ld;
            cycle(lr, ls, ld, ($urandom_range(0, 49) == 0) ? 0 : int'($urandom_range(1, 31)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
